load_use_hazard_sequencer: RTL and testbench

Pipeline hazard sequencer between the execute and memory stages of the ARM32 pipeline. It detects load-use hazards, where an LDR in the memory stage writes a register that the instruction in execute reads as Rn, Rm or Rs. It then freezes the front of the pipeline until data memory returns the load data. It also sequences the multi-cycle flush of younger instructions after a taken branch, and keeps stall statistics plus a sticky memory-timeout flag.

---
 rtl/load_use_hazard_sequencer.sv | 118 +++++++++++
 tb/tb_load_use_hazard_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/load_use_hazard_sequencer.sv
// rtl/load_use_hazard_sequencer.sv - load-use stall and branch-flush sequencer between execute and memory
module load_use_hazard_sequencer #(
   parameter int FLUSH_CYCLES = 2,
   parameter int MAX_WAIT     = 15,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [3:0]       ex_rn,
   input  logic [3:0]       ex_rm,
   input  logic [3:0]       ex_rs,
   input  logic             ex_use_rn,
   input  logic             ex_use_rm,
   input  logic             ex_use_rs,
   input  logic             mem_valid,
   input  logic             mem_is_load,
   input  logic [3:0]       mem_rd,
   input  logic             dmem_rvalid,
   input  logic             branch_taken,
   output logic             sel_stall,
   output logic             flush,
   output logic             fwd_load,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             wait_timeout
);

   localparam int WAIT_W  = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;
   localparam int FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      ST_RUN       = 2'b00,
      ST_LOAD_WAIT = 2'b01,
      ST_FLUSH     = 2'b10
   } state_e;

   state_e             state_q, state_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic               timeout_q, timeout_d;
   logic               hazard;

   assign hazard = ex_valid & mem_valid & mem_is_load &
                   ((ex_use_rn & (ex_rn == mem_rd)) |
                    (ex_use_rm & (ex_rm == mem_rd)) |
                    (ex_use_rs & (ex_rs == mem_rd)));

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      flush_cnt_d = flush_cnt_q;
      timeout_d   = timeout_q;
      sel_stall   = 1'b0;
      flush       = 1'b0;
      fwd_load    = 1'b0;
      case (state_q)
         ST_RUN: begin
            // A taken branch kills the hazarding instruction, so it outranks the stall
            if (branch_taken) begin
               state_d     = ST_FLUSH;
               flush_cnt_d = FLUSH_W'(FLUSH_CYCLES);
            end else if (hazard) begin
               if (dmem_rvalid) begin
                  fwd_load = 1'b1;
               end else begin
                  sel_stall  = 1'b1;
                  state_d    = ST_LOAD_WAIT;
                  wait_cnt_d = '0;
               end
            end
         end
         ST_LOAD_WAIT: begin
            if (dmem_rvalid) begin
               fwd_load = 1'b1;
               state_d  = ST_RUN;
            end else if (wait_cnt_q == WAIT_W'(MAX_WAIT)) begin
               timeout_d = 1'b1;
               state_d   = ST_RUN;
            end else begin
               sel_stall  = 1'b1;
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         ST_FLUSH: begin
            flush       = 1'b1;
            flush_cnt_d = flush_cnt_q - 1'b1;
            if (flush_cnt_q == FLUSH_W'(1)) begin
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_RUN;
      endcase
      stall_cnt_d = (sel_stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign state        = state_q;
   assign stall_cycles = stall_cnt_q;
   assign wait_timeout = timeout_q;

endmodule

// File: tb/tb_load_use_hazard_sequencer.sv
// tb/tb_load_use_hazard_sequencer.sv - scoreboard bench with a timeline-based reference model
module tb_load_use_hazard_sequencer;

   localparam int FC = 2;
   localparam int MW = 15;
   localparam int CW = 4;
   localparam int SAT = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_valid, ex_use_rn, ex_use_rm, ex_use_rs;
   logic [3:0]    ex_rn, ex_rm, ex_rs, mem_rd;
   logic          mem_valid, mem_is_load, dmem_rvalid, branch_taken;
   logic          sel_stall, flush, fwd_load, wait_timeout;
   logic [1:0]    state;
   logic [CW-1:0] stall_cycles;

   always #5 clk = ~clk;

   load_use_hazard_sequencer #(.FLUSH_CYCLES(FC), .MAX_WAIT(MW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .ex_valid(ex_valid), .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rs(ex_rs),
      .ex_use_rn(ex_use_rn), .ex_use_rm(ex_use_rm), .ex_use_rs(ex_use_rs),
      .mem_valid(mem_valid), .mem_is_load(mem_is_load), .mem_rd(mem_rd),
      .dmem_rvalid(dmem_rvalid), .branch_taken(branch_taken),
      .sel_stall(sel_stall), .flush(flush), .fwd_load(fwd_load), .state(state),
      .stall_cycles(stall_cycles), .wait_timeout(wait_timeout)
   );

   typedef struct {
      int cyc;
      bit stall;
      bit flsh;
      bit fwd;
      int st;
      int cnt;
      bit to;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model tracks events on an absolute cycle timeline
   int cyc = 0;
   bit m_waiting = 1'b0;
   int m_wait_start = 0;
   int m_flush_end = -1;
   int m_stalls = 0;
   bit m_to = 1'b0;

   task automatic chk(input string name, input int c, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s cycle %0d actual %0d required %0d", name, c, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("sel_stall", e.cyc, int'(sel_stall), int'(e.stall));
         chk("flush", e.cyc, int'(flush), int'(e.flsh));
         chk("fwd_load", e.cyc, int'(fwd_load), int'(e.fwd));
         chk("state", e.cyc, int'(state), e.st);
         chk("stall_cycles", e.cyc, int'(stall_cycles), e.cnt);
         chk("wait_timeout", e.cyc, int'(wait_timeout), int'(e.to));
      end
   end

   task automatic step(input bit r, input bit ev, input logic [3:0] rn, input logic [3:0] rm,
                       input logic [3:0] rs, input bit urn, input bit urm, input bit urs,
                       input bit mv, input bit ml, input logic [3:0] rd, input bit rv,
                       input bit br);
      exp_t e;
      bit   haz;
      int   k;
      bit   end_wait;
      rst = r; ex_valid = ev; ex_rn = rn; ex_rm = rm; ex_rs = rs;
      ex_use_rn = urn; ex_use_rm = urm; ex_use_rs = urs;
      mem_valid = mv; mem_is_load = ml; mem_rd = rd; dmem_rvalid = rv; branch_taken = br;
      haz = ev && mv && ml && ((urn && rn == rd) || (urm && rm == rd) || (urs && rs == rd));
      e.cyc = cyc; e.stall = 0; e.flsh = 0; e.fwd = 0; e.st = 0;
      e.cnt = m_stalls; e.to = m_to;
      end_wait = 1'b0;
      if (!r) begin
         if (cyc <= m_flush_end) begin
            e.flsh = 1; e.st = 2;
         end else if (m_waiting) begin
            e.st = 1;
            k = cyc - m_wait_start - 1;
            if (rv) begin
               e.fwd = 1; end_wait = 1;
            end else if (k == MW) begin
               end_wait = 1;
            end else begin
               e.stall = 1;
            end
         end else if (br) begin
            m_flush_end = cyc + FC;
         end else if (haz) begin
            if (rv) e.fwd = 1;
            else begin
               e.stall = 1; m_waiting = 1; m_wait_start = cyc;
            end
         end
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (r) begin
         m_waiting = 0; m_flush_end = -1; m_stalls = 0; m_to = 0;
      end else begin
         if (end_wait) begin
            m_waiting = 0;
            if (!rv) m_to = 1;
         end
         if (e.stall && m_stalls < SAT) m_stalls++;
      end
      cyc++;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) step(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Execute reads rm=3 while LDR r3 sits in memory
   task automatic haz_rm(input int n, input bit rv, input bit br);
      for (int i = 0; i < n; i++) step(0, 1, 4'd1, 4'd3, 4'd2, 1, 1, 0, 1, 1, 4'd3, rv, br);
   endtask

   initial begin
      bit rv_rare;
      idle(2, 1);
      idle(1, 0);
      haz_rm(3, 0, 0);
      haz_rm(1, 1, 0);
      idle(2, 0);
      step(0, 1, 4'd1, 4'd2, 4'd7, 1, 1, 0, 1, 1, 4'd7, 0, 0);
      step(0, 1, 4'd1, 4'd3, 4'd2, 1, 1, 0, 1, 0, 4'd3, 0, 0);
      step(0, 0, 4'd1, 4'd3, 4'd2, 1, 1, 0, 1, 1, 4'd3, 0, 0);
      haz_rm(1, 1, 0);
      idle(1, 0);
      haz_rm(1, 0, 1);
      haz_rm(1, 0, 1);
      haz_rm(1, 0, 0);
      idle(3, 0);
      haz_rm(1, 0, 0);
      idle(20, 0);
      idle(1, 1);
      idle(2, 0);
      haz_rm(22, 0, 0);
      idle(1, 0);
      haz_rm(4, 0, 0);
      idle(1, 1);
      idle(2, 0);
      step(0, 1, 4'd15, 4'd0, 4'd0, 1, 0, 0, 1, 1, 4'd15, 0, 0);
      idle(1, 0);
      step(0, 1, 4'd0, 4'd0, 4'd9, 0, 0, 1, 1, 1, 4'd9, 1, 0);
      for (int i = 0; i < 1500; i++) begin
         rv_rare = ((i / 200) % 2) == 1;
         step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8,
              4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
              $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, 4'($urandom_range(0, 3)),
              rv_rare ? ($urandom_range(0, 49) == 0) : ($urandom_range(0, 9) < 3),
              $urandom_range(0, 99) < 8);
      end
      idle(2, 0);
      @(negedge clk);
      chk("scoreboard_drained", cyc, sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
